// File: rtl/temp_pkg.sv
// temp_pkg: shared constants, FSM state type and width helper for the temp_filter slice.
package temp_pkg;

  // Width of the period count delivered by the counter stage.
  localparam int unsigned CNT_W = 8;

  // Filter sequencing: drop the partial first count, fill the window, then slide.
  typedef enum logic [1:0] {
    DISCARD = 2'd0,
    FILL    = 2'd1,
    RUN     = 2'd2
  } temp_filt_state_t;

  // Accumulator width: the sum of 2^log2_n counts of CNT_W bits never overflows this.
  function automatic int unsigned acc_width(input int unsigned log2_n);
    return CNT_W + log2_n;
  endfunction

endpackage

// File: rtl/temp_sample_ring.sv
// temp_sample_ring: N-entry circular buffer of period counts.
// The write pointer advances on every write and wraps naturally. oldest_o is the entry the
// next write will replace, i.e. the sample leaving the averaging window.
module temp_sample_ring
  import temp_pkg::*;
#(
  parameter int unsigned LOG2_N = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we_i,
  input  logic [CNT_W-1:0] wdata_i,
  output logic [CNT_W-1:0] oldest_o
);

  localparam int unsigned N = 1 << LOG2_N;

  logic [CNT_W-1:0]  mem_q [N];
  logic [LOG2_N-1:0] wr_ptr_q;
  logic [LOG2_N-1:0] wr_ptr_d;

  // Pointer advance; N is a power of two so the wrap is free.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    if (we_i) begin
      wr_ptr_d = wr_ptr_q + LOG2_N'(1);
    end
  end

  // Pointer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
    end
  end

  // Storage: no reset needed, the fill phase writes every entry before any is read.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  assign oldest_o = mem_q[wr_ptr_q];

endmodule

// File: rtl/temp_filter.sv
// temp_filter: moving average of the relaxation-oscillator period count.
// Captures b one cycle after each analog_out rising edge, drops the first (partial) count
// after reset, averages the last 2^LOG2_N samples and offers the result on valid/ready.
// Optional hysteresis alarm is built when TEMP_FILTER_ALARM_EN is defined; otherwise alarm
// is tied low.
module temp_filter
  import temp_pkg::*;
#(
  parameter int unsigned LOG2_N   = 2,
  parameter logic [7:0]  ALARM_HI = 8'd200,
  parameter logic [7:0]  ALARM_LO = 8'd180
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       analog_out,
  input  logic [7:0] b,
  output logic [7:0] avg,
  output logic       avg_valid,
  input  logic       avg_ready,
  output logic       overrun,
  output logic       alarm
);

  localparam int unsigned N    = 1 << LOG2_N;
  localparam int unsigned AccW = acc_width(LOG2_N);

  // Reject illegal configurations at elaboration.
  if (LOG2_N < 1 || LOG2_N > 4) begin : g_bad_log2_n
    $error("temp_filter: LOG2_N must be in 1..4");
  end
  if (ALARM_LO >= ALARM_HI) begin : g_bad_thresholds
    $error("temp_filter: ALARM_LO must be below ALARM_HI");
  end

  // ---------------------------------------------------------------------------------------
  // Edge detect, identical to the counter stage so both see the same edge.
  // ---------------------------------------------------------------------------------------
  logic out_d_q;
  logic edge_q;

  // Register comparator output and flag its rising edge one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_d_q <= 1'b0;
      edge_q  <= 1'b0;
    end else begin
      out_d_q <= analog_out;
      edge_q  <= analog_out & ~out_d_q;
    end
  end

  // ---------------------------------------------------------------------------------------
  // Sequencing and accumulator.
  // ---------------------------------------------------------------------------------------
  temp_filt_state_t  state_q, state_d;
  logic [LOG2_N-1:0] fill_cnt_q, fill_cnt_d;
  logic [AccW-1:0]   acc_q, acc_d;
  logic              ring_we;
  logic              launch;
  logic [CNT_W-1:0]  oldest;

  temp_sample_ring #(
    .LOG2_N (LOG2_N)
  ) u_ring (
    .clk      (clk),
    .rst_n    (rst_n),
    .we_i     (ring_we),
    .wdata_i  (b),
    .oldest_o (oldest)
  );

  // Next-state: every capture is handled in the cycle edge_q is high (fully pipelined).
  always_comb begin
    state_d    = state_q;
    fill_cnt_d = fill_cnt_q;
    acc_d      = acc_q;
    ring_we    = 1'b0;
    launch     = 1'b0;
    if (edge_q) begin
      case (state_q)
        DISCARD: begin
          state_d = FILL;
        end
        FILL: begin
          ring_we    = 1'b1;
          acc_d      = acc_q + AccW'(b);
          fill_cnt_d = fill_cnt_q + LOG2_N'(1);
          if (fill_cnt_q == LOG2_N'(N - 1)) begin
            state_d = RUN;
            launch  = 1'b1;
          end
        end
        RUN: begin
          ring_we = 1'b1;
          // Intermediate sum may wrap modulo 2^AccW; the final window sum always fits.
          acc_d   = acc_q + AccW'(b) - AccW'(oldest);
          launch  = 1'b1;
        end
        default: begin
          state_d = DISCARD;
        end
      endcase
    end
  end

  // FSM, fill counter and accumulator registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= DISCARD;
      fill_cnt_q <= '0;
      acc_q      <= '0;
    end else begin
      state_q    <= state_d;
      fill_cnt_q <= fill_cnt_d;
      acc_q      <= acc_d;
    end
  end

  // ---------------------------------------------------------------------------------------
  // Result register and valid/ready handshake.
  // ---------------------------------------------------------------------------------------
  logic [7:0] avg_q, avg_d;
  logic       avg_valid_q, avg_valid_d;
  logic       overrun_q, overrun_d;

  // A launch always wins over a consume; overrun only when an unconsumed value is lost.
  always_comb begin
    avg_d       = avg_q;
    avg_valid_d = avg_valid_q;
    overrun_d   = overrun_q;
    if (launch) begin
      avg_d       = acc_d[AccW-1:LOG2_N];
      avg_valid_d = 1'b1;
      if (avg_valid_q && !avg_ready) begin
        overrun_d = 1'b1;
      end
    end else if (avg_valid_q && avg_ready) begin
      avg_valid_d = 1'b0;
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      avg_q       <= '0;
      avg_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      avg_q       <= avg_d;
      avg_valid_q <= avg_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign avg       = avg_q;
  assign avg_valid = avg_valid_q;
  assign overrun   = overrun_q;

  // ---------------------------------------------------------------------------------------
  // Hysteresis alarm, evaluated on the freshly launched average one cycle after launch.
  // ---------------------------------------------------------------------------------------
`ifdef TEMP_FILTER_ALARM_EN
  logic launch_q;
  logic alarm_q, alarm_d;

  // Set at or above the high threshold, clear at or below the low one, else hold.
  always_comb begin
    alarm_d = alarm_q;
    if (launch_q) begin
      if (avg_q >= ALARM_HI) begin
        alarm_d = 1'b1;
      end else if (avg_q <= ALARM_LO) begin
        alarm_d = 1'b0;
      end
    end
  end

  // Launch delay and alarm register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      launch_q <= 1'b0;
      alarm_q  <= 1'b0;
    end else begin
      launch_q <= launch;
      alarm_q  <= alarm_d;
    end
  end

  assign alarm = alarm_q;
`else
  assign alarm = 1'b0;
`endif

endmodule

// File: tb/tb_temp_filter.sv
// tb_temp_filter: directed literal checks plus randomized stimulus, with a window-average
// reference model compared against the DUT on every cycle.
module tb_temp_filter;

  localparam int LOG2_N = 2;
  localparam int N      = 1 << LOG2_N;
  localparam int HI     = 200;
  localparam int LO     = 180;

  logic       clk;
  logic       rst_n;
  logic       analog_out;
  logic [7:0] b;
  logic [7:0] avg;
  logic       avg_valid;
  logic       avg_ready;
  logic       overrun;
  logic       alarm;

  int n_tests = 0;
  int n_fail  = 0;
  bit cmp_en  = 0;

  temp_filter #(
    .LOG2_N   (LOG2_N),
    .ALARM_HI (8'(HI)),
    .ALARM_LO (8'(LO))
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .analog_out (analog_out),
    .b          (b),
    .avg        (avg),
    .avg_valid  (avg_valid),
    .avg_ready  (avg_ready),
    .overrun    (overrun),
    .alarm      (alarm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------------------
  // Reference model: the list of accepted samples; a result is the truncated mean of the
  // last N of them once N exist. A rising analog_out seen at one posedge is captured with
  // the b present at the following posedge.
  // ---------------------------------------------------------------------------------------
  int   m_samples[$];
  int   m_caps;
  bit   m_prev_ana, m_pending, m_launch_prev;
  int   m_avg;
  bit   m_valid, m_ovr, m_alarm;

  task automatic model_reset();
    m_samples.delete();
    m_caps = 0; m_prev_ana = 0; m_pending = 0; m_launch_prev = 0;
    m_avg = 0; m_valid = 0; m_ovr = 0; m_alarm = 0;
  endtask

  task automatic model_step();
    bit launch;
    int sum;
    launch = 0;
`ifdef TEMP_FILTER_ALARM_EN
    if (m_launch_prev) begin
      if (m_avg >= HI) m_alarm = 1;
      else if (m_avg <= LO) m_alarm = 0;
    end
`endif
    if (m_pending) begin
      m_caps++;
      if (m_caps > 1) begin
        m_samples.push_back(int'(b));
        if (m_samples.size() > N) void'(m_samples.pop_front());
        if (m_samples.size() == N) begin
          sum = 0;
          foreach (m_samples[i]) sum += m_samples[i];
          launch = 1;
          if (m_valid && !avg_ready) m_ovr = 1;
          m_avg   = sum / N;
          m_valid = 1;
        end
      end
    end
    if (!launch && m_valid && avg_ready) m_valid = 0;
    m_pending     = analog_out && !m_prev_ana;
    m_prev_ana    = analog_out;
    m_launch_prev = launch;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  // Every-cycle comparison, half a period away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (cmp_en) begin
        check("cyc_avg", int'(avg), m_avg);
        check("cyc_valid", int'(avg_valid), int'(m_valid));
        check("cyc_overrun", int'(overrun), int'(m_ovr));
        check("cyc_alarm", int'(alarm), int'(m_alarm));
      end
    end
  end

  // ---------------------------------------------------------------------------------------
  // Directed helpers.
  // ---------------------------------------------------------------------------------------
  logic       s_vpre, s_vpost, s_opost, s_al;
  logic [7:0] s_apost;

  task automatic reset_dut();
    @(negedge clk);
    rst_n = 1'b0; analog_out = 1'b0; avg_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One comparator edge carrying count v. Optionally raise avg_ready only in the capture
  // (launch) cycle. Samples valid before capture, the result after it, and alarm a cycle on.
  task automatic send(input logic [7:0] v, input bit rdy_pulse);
    @(negedge clk); analog_out = 1'b1; b = v;
    @(negedge clk); analog_out = 1'b0; s_vpre = avg_valid;
    if (rdy_pulse) avg_ready = 1'b1;
    @(negedge clk); #1;
    s_vpost = avg_valid; s_apost = avg; s_opost = overrun;
    if (rdy_pulse) avg_ready = 1'b0;
    @(negedge clk); #1;
    s_al = alarm;
  endtask

  int exp_al[6];

  initial begin
    rst_n = 1'b0; analog_out = 1'b0; b = 8'd0; avg_ready = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    check("reset_avg", int'(avg), 0);
    check("reset_valid", int'(avg_valid), 0);
    check("reset_overrun", int'(overrun), 0);
    check("reset_alarm", int'(alarm), 0);
    rst_n = 1'b1;
    cmp_en = 1;

    // Discard, fill, steady state, launch-with-accept, backpressure.
    send(8'd99, 0); send(8'd10, 0); send(8'd20, 0); send(8'd30, 0);
    check("fill_not_valid", int'(s_vpost), 0);
    send(8'd40, 0);
    check("first_valid_pre", int'(s_vpre), 0);
    check("first_valid", int'(s_vpost), 1);
    check("first_avg", int'(s_apost), 25);
    check("first_overrun", int'(s_opost), 0);
    send(8'd50, 1);
    check("simul_avg", int'(s_apost), 35);
    check("simul_valid", int'(s_vpost), 1);
    check("simul_overrun", int'(s_opost), 0);
    send(8'd60, 0);
    check("bp_avg", int'(s_apost), 45);
    check("bp_valid", int'(s_vpost), 1);
    check("bp_overrun", int'(s_opost), 1);
    @(negedge clk); avg_ready = 1'b1;
    @(negedge clk); avg_ready = 1'b0; #1;
    check("bp_drain_valid", int'(avg_valid), 0);
    check("bp_sticky_overrun", int'(overrun), 1);

    // Asynchronous reset clears outputs without a clock edge.
    @(posedge clk); #2; rst_n = 1'b0; #1;
    check("async_avg", int'(avg), 0);
    check("async_overrun", int'(overrun), 0);
    @(negedge clk); rst_n = 1'b1;

    // Saturated values and ring wrap.
    send(8'd99, 0);
    repeat (4) send(8'd255, 0);
    check("sat_avg", int'(s_apost), 255);
    send(8'd0, 0); check("drain_191", int'(s_apost), 191);
    send(8'd0, 0); check("drain_127", int'(s_apost), 127);
    send(8'd0, 0); check("drain_63", int'(s_apost), 63);
    send(8'd0, 0); check("drain_0", int'(s_apost), 0);

    // Reset mid-FILL restarts from discard.
    reset_dut();
    send(8'd5, 0); send(8'd100, 0); send(8'd100, 0);
    reset_dut();
    send(8'd7, 0); send(8'd200, 0); send(8'd200, 0); send(8'd200, 0);
    check("refill_not_valid", int'(s_vpost), 0);
    send(8'd200, 0);
    check("refill_valid", int'(s_vpost), 1);
    check("refill_avg", int'(s_apost), 200);

    // Alarm hysteresis: averages 150,162,175,187,200,190,180.
`ifdef TEMP_FILTER_ALARM_EN
    exp_al = '{0, 0, 0, 1, 1, 0};
`else
    exp_al = '{0, 0, 0, 0, 0, 0};
`endif
    reset_dut();
    send(8'd9, 0);
    repeat (4) send(8'd150, 0);
    check("alarm_150_avg", int'(s_apost), 150);
    check("alarm_150", int'(s_al), exp_al[0]);
    send(8'd200, 0); send(8'd200, 0);
    send(8'd200, 0);
    check("alarm_187", int'(s_al), exp_al[1]);
    send(8'd200, 0);
    check("alarm_200_avg", int'(s_apost), 200);
    check("alarm_200", int'(s_al), exp_al[3]);
    send(8'd160, 0);
    check("alarm_190_avg", int'(s_apost), 190);
    check("alarm_190", int'(s_al), exp_al[4]);
    send(8'd160, 0);
    check("alarm_180_avg", int'(s_apost), 180);
    check("alarm_180", int'(s_al), exp_al[5]);

    // Randomized stimulus; the per-cycle compare does the checking.
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      analog_out = 1'($urandom_range(0, 1));
      if ((i / 250) % 2 == 1) b = 8'($urandom_range(160, 255));
      else b = 8'($urandom);
      avg_ready = ($urandom_range(0, 3) == 0);
      rst_n = ($urandom_range(0, 599) != 0);
    end
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
